// File: rtl/spi_flash_reader.sv
// Each CPU read in the flash window becomes one SPI read (0x03). `SPI_FAST_READ_EN selects 0x0B plus 8 dummy clocks.
// Data is valid 1+2*CLK_DIV*N cycles after the request (N=40, or 48 with fast read). o_mrdy stalls the CPU meanwhile, and the bus is released while i_FT_CS is low.
module spi_flash_reader #(
  parameter int          CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_spi_ce,
  input  logic        i_FT_CS,
  input  logic        i_rw,
  input  logic [15:0] i_addr,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_mrdy,
  output logic        o_spi_cs_n,
  output logic        o_spi_sclk,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso,
  output logic        o_spi_oe
);

`ifdef SPI_FAST_READ_EN
  localparam int          N_BITS = 48;
  localparam logic [7:0]  RD_CMD = 8'h0B;
`else
  localparam int          N_BITS = 40;
  localparam logic [7:0]  RD_CMD = 8'h03;
`endif
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]       LAST_BIT = 6'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DONE
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [N_BITS-1:0] tx_sr;
  logic [7:0]        rx_sr;
  logic              req;
  logic              busy;
  logic [23:0]       flash_addr;
  logic [N_BITS-1:0] frame;
  logic              addr_hi_unused;

  // Upper address bits are already decoded into i_spi_ce.
  assign addr_hi_unused = ^i_addr[15:12];

  // Gating with reset keeps o_mrdy at its reset value while reset is held.
  assign req        = i_spi_ce & i_rw & i_FT_CS & i_reset_n;
  assign busy       = state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
  assign flash_addr = FLASH_BASE + {12'h000, i_addr[11:0]};
  assign frame      = {RD_CMD, flash_addr, {(N_BITS - 32){1'b0}}};

  assign o_mrdy   = ~((state == S_IDLE && req) || busy);
  assign o_spi_oe = i_FT_CS;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_spi_cs_n   <= 1'b1;
      o_spi_sclk   <= 1'b0;
      o_spi_mosi   <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state      <= S_CMD;
            o_spi_cs_n <= 1'b0;
            o_spi_sclk <= 1'b0;
            o_spi_mosi <= frame[N_BITS-1];
            tx_sr      <= frame << 1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
          end
        end
        S_DONE: begin
          if (!i_spi_ce) state <= S_IDLE;
        end
        default: begin
          if (!i_FT_CS) begin
            state      <= S_IDLE;
            o_spi_cs_n <= 1'b1;
            o_spi_sclk <= 1'b0;
            o_spi_mosi <= 1'b0;
          end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt    <= '0;
            o_spi_sclk <= ~o_spi_sclk;
            if (!o_spi_sclk) begin
              rx_sr <= {rx_sr[6:0], i_spi_miso};
            end else if (bit_cnt == LAST_BIT) begin
              // The final falling edge coincides with cs_n release and data return.
              state        <= S_DONE;
              o_spi_cs_n   <= 1'b1;
              o_spi_mosi   <= 1'b0;
              o_data       <= rx_sr;
              o_data_valid <= 1'b1;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              o_spi_mosi <= tx_sr[N_BITS-1];
              tx_sr      <= tx_sr << 1;
              case (bit_cnt)
                6'd7:  state <= S_ADDR;
`ifdef SPI_FAST_READ_EN
                6'd31: state <= S_DUMMY;
                6'd39: state <= S_DATA;
`else
                6'd31: state <= S_DATA;
`endif
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
